dmac_slave_regfile: RTL and testbench
=====================================

# dmac_slave_regfile

Parametrised register front-end of the DMA controller: the successor to the DMAC's combinational 8-way register read path. It holds the programming registers (source, destination, size, interrupt enable) behind a synchronous bus slave with registered read data. It queues programmed transfers as descriptors in an internal FIFO and hands them to the DMA engine over a valid/ready port. It also tracks in-flight transfers and raises the completion interrupt.

## Interface
- DATA_W, 32: bus data width, and width of the SRC and DST registers (≥16)
- ADDR_W, 3: word-address width of the slave port
- FIFO_DEPTH, 4: descriptor queue depth (power of 2, ≥2)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- s_sel  in  1  slave select
- s_wr  in  1  1 = write, 0 = read (qualified by s_sel)
- s_addr  in  ADDR_W  register word index
- s_din  in  DATA_W  write data
- s_dout  out  DATA_W  registered read data
- desc_valid  out  1  descriptor available at FIFO head
- desc_ready  in  1  engine accepts head descriptor
- desc_src / desc_dst  out  DATA_W  head source/destination address
- desc_size  out  16  head transfer size (bytes)
- op_done  in  1  one-cycle pulse from engine: one transfer finished
- irq  out  1  INTERRUPT & INT_EN

## Operation
- Register map (word index):
  - 0 OPSTART: W; write with bit0=1 pushes {SRC, DST, SIZE} as a descriptor; reads 0
  - 1 INTERRUPT: R; bit0; write bit0=1 clears it (W1C)
  - 2 INT_EN: R/W; bit0
  - 3 SRC: R/W; DATA_W bits
  - 4 DST: R/W; DATA_W bits
  - 5 SIZE: R/W; [15:0], upper bits read 0
  - 6 STATUS: R; bit0 busy, bit1 overflow (sticky), bits[15:8] FIFO count; write bit1=1 clears overflow
  - 7 and any unmapped index: reads 0, writes ignored
- Push while full, with no pop in the same cycle: descriptor dropped, overflow set.
- Push while full with a pop in the same cycle: push accepted.
- Pop occurs when desc_valid & desc_ready. Pop increments outstanding (8-bit, saturating at 255).
- op_done decrements outstanding; op_done while outstanding==0 is ignored.
- INTERRUPT set on the cycle op_done brings outstanding to 0 while the FIFO is empty and no push or pop is happening.
- Set beats a same-cycle W1C clear.
- busy = FIFO non-empty | outstanding≠0.
- SRC, DST and SIZE keep their values after a push, so back-to-back pushes repeat the same descriptor.

## Timing
- Reset: all registers, FIFO pointers/count, outstanding, overflow, and INTERRUPT are 0. s_dout=0, desc_valid=0, irq=0; desc_* outputs are 0.
- Write: takes effect on the clk edge where s_sel&s_wr. A read of the same register in the next cycle returns the new value.
- Read: s_dout loads on the edge where s_sel&!s_wr, giving a 1-cycle latency. s_dout holds its value otherwise.
- Push to an empty FIFO: desc_valid rises on the following edge; there is no same-cycle bypass.
- desc_* are driven from the FIFO head, stable while desc_valid & !desc_ready.
- irq is combinational from registered INTERRUPT & INT_EN.
- Reset mid-transfer: queue and outstanding are discarded immediately. The engine must also be reset.

## Structure
- Shared package dmac_pkg (or a defines include): register index constants, STATUS bit positions, SIZE_W=16.
- Sub-module dmac_desc_fifo:
  - parameters: width 2·DATA_W+16, depth FIFO_DEPTH
  - push/pop/full/empty/count
  - wrap-around pointers with an extra MSB
- The top holds the register decode, read mux, and outstanding/interrupt logic.

## Test plan
- Reset, then read all 8 indices → all return 0; irq=0, desc_valid=0.
- Write SRC=0x1000, DST=0x2000, SIZE=0x0040, then OPSTART=1 → desc_valid=1 one cycle later with those values; STATUS count=1, busy=1.
- Push 5 descriptors with desc_ready=0 (FIFO_DEPTH=4) → count=4, overflow=1. Pop all → same order, 4th and 5th-attempt not duplicated. Write STATUS=0x2 → overflow=0.
- INT_EN=1; push 1, pop, pulse op_done → INTERRUPT=1, irq=1, busy=0. Write INTERRUPT=1 → irq=0 next cycle.
- Full FIFO with simultaneous push and desc_ready=1 → count stays 4, no overflow, new descriptor emerges last.
- Assert reset with 2 queued and 1 outstanding → desc_valid=0, STATUS=0, irq=0 asynchronously; a subsequent op_done is ignored.

Source files
------------

// File: rtl/dmac_pkg.sv
// Purpose: shared constants for the DMA controller register front-end.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dmac_pkg;

    // Width of the SIZE register and of the descriptor size field.
    localparam int SIZE_W = 16;

    // Register word indices on the slave port.
    localparam int REG_OPSTART   = 0;
    localparam int REG_INTERRUPT = 1;
    localparam int REG_INT_EN    = 2;
    localparam int REG_SRC       = 3;
    localparam int REG_DST       = 4;
    localparam int REG_SIZE      = 5;
    localparam int REG_STATUS    = 6;

    // STATUS register layout.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_OVF     = 1;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 8;

    // Saturation value of the in-flight transfer counter.
    localparam logic [7:0] OUTSTANDING_MAX = 8'hFF;

endpackage

// File: rtl/dmac_desc_fifo.sv
// Purpose: generic synchronous FIFO holding DMA descriptors.
// Latency: a push is visible at the head on the edge after it is written (no bypass).
// Backpressure: push is refused when full unless a pop happens in the same cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push_vld, push_dat  write request and data
//   pop_vld             remove head entry (ignored when empty)
//   full, empty, count  occupancy flags and entry count
//   head_dat            head entry, forced to 0 while empty
module dmac_desc_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra MSB so full and empty are told apart
    // without a separate counter.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop_vld & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push_vld & (~full | do_pop);

    // Head is gated so downstream sees zeros rather than stale storage.
    assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only observable once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/dmac_slave_regfile.sv
// Purpose: DMAC programming registers, descriptor queue and completion interrupt.
// Latency: register reads 1 cycle; a pushed descriptor reaches desc_valid 1 cycle later.
// Backpressure: desc_* held while desc_valid & !desc_ready; pushes to a full queue drop and set overflow.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   s_sel, s_wr, s_addr, s_din, s_dout slave bus (registered read data)
//   desc_valid, desc_ready             descriptor handshake to the DMA engine
//   desc_src, desc_dst, desc_size      head descriptor fields
//   op_done                            engine pulse: one transfer finished
//   irq                                INTERRUPT & INT_EN
module dmac_slave_regfile
    import dmac_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [DATA_W-1:0] desc_src,
    output logic [DATA_W-1:0] desc_dst,
    output logic [SIZE_W-1:0] desc_size,
    input  logic              op_done,
    output logic              irq
);

    localparam int DESC_W = 2*DATA_W + SIZE_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic              wr_vld;
    logic              rd_vld;
    logic              push_req;
    logic              desc_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DESC_W-1:0] head_dat;

    logic [DATA_W-1:0] src_q;
    logic [DATA_W-1:0] dst_q;
    logic [SIZE_W-1:0] size_q;
    logic              int_en_q;
    logic              interrupt_q;
    logic              overflow_q;
    logic [7:0]        outstanding_q;

    logic              out_dec;
    logic [8:0]        out_sum;
    logic              int_set;
    logic              busy;
    logic [DATA_W-1:0] status_dat;
    logic [DATA_W-1:0] rd_dat;

    function automatic logic hit(input logic [ADDR_W-1:0] a, input int idx);
        return a == ADDR_W'(idx);
    endfunction

    assign wr_vld   = s_sel & s_wr;
    assign rd_vld   = s_sel & ~s_wr;
    assign push_req = wr_vld & hit(s_addr, REG_OPSTART) & s_din[0];
    assign desc_pop = desc_valid & desc_ready;

    dmac_desc_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_req),
        .push_dat ({src_q, dst_q, size_q}),
        .pop_vld  (desc_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head_dat (head_dat)
    );

    assign desc_valid                       = ~fifo_empty;
    assign {desc_src, desc_dst, desc_size}  = head_dat;

    // Completions with nothing in flight are spurious and dropped.
    assign out_dec = op_done & (outstanding_q != '0);
    assign out_sum = {1'b0, outstanding_q} + 9'(desc_pop) - 9'(out_dec);

    // The last completion only counts as "all done" if nothing is queued
    // or about to be queued / launched in the same cycle.
    assign int_set = out_dec & (outstanding_q == 8'd1) & fifo_empty & ~push_req & ~desc_pop;

    assign busy = ~fifo_empty | (outstanding_q != '0);
    assign irq  = interrupt_q & int_en_q;

    always_comb begin
        status_dat = '0;
        status_dat[STAT_BUSY] = busy;
        status_dat[STAT_OVF]  = overflow_q;
        status_dat[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);

        rd_dat = '0;
        case (s_addr)
            ADDR_W'(REG_INTERRUPT): rd_dat = DATA_W'(interrupt_q);
            ADDR_W'(REG_INT_EN):    rd_dat = DATA_W'(int_en_q);
            ADDR_W'(REG_SRC):       rd_dat = src_q;
            ADDR_W'(REG_DST):       rd_dat = dst_q;
            ADDR_W'(REG_SIZE):      rd_dat = DATA_W'(size_q);
            ADDR_W'(REG_STATUS):    rd_dat = status_dat;
            default:                rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q         <= '0;
            dst_q         <= '0;
            size_q        <= '0;
            int_en_q      <= 1'b0;
            interrupt_q   <= 1'b0;
            overflow_q    <= 1'b0;
            outstanding_q <= '0;
            s_dout        <= '0;
        end else begin
            if (wr_vld && hit(s_addr, REG_INT_EN)) int_en_q <= s_din[0];
            if (wr_vld && hit(s_addr, REG_SRC))    src_q    <= s_din;
            if (wr_vld && hit(s_addr, REG_DST))    dst_q    <= s_din;
            if (wr_vld && hit(s_addr, REG_SIZE))   size_q   <= s_din[SIZE_W-1:0];

            // Set takes priority over a same-cycle write-one-to-clear.
            if (int_set)
                interrupt_q <= 1'b1;
            else if (wr_vld && hit(s_addr, REG_INTERRUPT) && s_din[0])
                interrupt_q <= 1'b0;

            if (push_req && fifo_full && !desc_pop)
                overflow_q <= 1'b1;
            else if (wr_vld && hit(s_addr, REG_STATUS) && s_din[STAT_OVF])
                overflow_q <= 1'b0;

            outstanding_q <= out_sum[8] ? OUTSTANDING_MAX : out_sum[7:0];

            if (rd_vld) s_dout <= rd_dat;
        end
    end

endmodule

// File: tb/tb_dmac_slave_regfile.sv
// Purpose: self-checking bench for dmac_slave_regfile (directed scenarios plus random traffic).
// Latency: model advances on each rising edge; outputs compared 1 time unit later.
// Backpressure: desc_ready driven randomly / per scenario.
module tb_dmac_slave_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_sel = 1'b0;
    logic              s_wr = 1'b0;
    logic [ADDR_W-1:0] s_addr = '0;
    logic [DATA_W-1:0] s_din = '0;
    logic [DATA_W-1:0] s_dout;
    logic              desc_valid;
    logic              desc_ready = 1'b0;
    logic [DATA_W-1:0] desc_src;
    logic [DATA_W-1:0] desc_dst;
    logic [15:0]       desc_size;
    logic              op_done = 1'b0;
    logic              irq;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    dmac_slave_regfile #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_sel      (s_sel),
        .s_wr       (s_wr),
        .s_addr     (s_addr),
        .s_din      (s_din),
        .s_dout     (s_dout),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_src   (desc_src),
        .desc_dst   (desc_dst),
        .desc_size  (desc_size),
        .op_done    (op_done),
        .irq        (irq)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] size;
    } desc_t;

    desc_t       mq[$];
    bit          m_int_en = 0;
    bit          m_intr   = 0;
    bit          m_ovf    = 0;
    logic [31:0] m_src    = '0;
    logic [31:0] m_dst    = '0;
    logic [15:0] m_size   = '0;
    int          m_out    = 0;
    logic [31:0] m_dout   = '0;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd1: r[0] = m_intr;
            3'd2: r[0] = m_int_en;
            3'd3: r = m_src;
            3'd4: r = m_dst;
            3'd5: r[15:0] = m_size;
            3'd6: begin
                r[0]    = (mq.size() != 0) || (m_out != 0);
                r[1]    = m_ovf;
                r[15:8] = 8'(mq.size());
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_step();
        bit wr_e, rd_e, pop, push, set_int;
        int dec;
        if (reset) begin
            mq.delete();
            m_int_en = 0; m_intr = 0; m_ovf = 0;
            m_src = '0; m_dst = '0; m_size = '0;
            m_out = 0; m_dout = '0;
        end else begin
            wr_e = s_sel && s_wr;
            rd_e = s_sel && !s_wr;
            pop  = (mq.size() != 0) && desc_ready;
            push = wr_e && (s_addr == 3'd0) && s_din[0];
            if (rd_e) m_dout = m_read(s_addr);
            set_int = op_done && (m_out == 1) && (mq.size() == 0) && !push;
            dec = (op_done && m_out > 0) ? 1 : 0;
            m_out = m_out + (pop ? 1 : 0) - dec;
            if (m_out > 255) m_out = 255;
            if (wr_e && s_addr == 3'd6 && s_din[1]) m_ovf = 0;
            if (pop) mq.delete(0);
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back('{m_src, m_dst, m_size});
                else m_ovf = 1;
            end
            if (wr_e && s_addr == 3'd1 && s_din[0]) m_intr = 0;
            if (set_int) m_intr = 1;
            if (wr_e) begin
                case (s_addr)
                    3'd2: m_int_en = s_din[0];
                    3'd3: m_src = s_din;
                    3'd4: m_dst = s_din;
                    3'd5: m_size = s_din[15:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare();
        check("s_dout", s_dout, m_dout);
        check("desc_valid", desc_valid, mq.size() != 0);
        check("irq", irq, m_intr && m_int_en);
        if (mq.size() != 0) begin
            check("desc_src", desc_src, mq[0].src);
            check("desc_dst", desc_dst, mq[0].dst);
            check("desc_size", desc_size, mq[0].size);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compare();
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit sel, input bit wr, input logic [2:0] a,
                         input logic [31:0] d, input bit rdy, input bit opd);
        @(negedge clk);
        s_sel = sel; s_wr = wr; s_addr = a; s_din = d;
        desc_ready = rdy; op_done = opd;
    endtask

    // One active cycle followed by inputs returning to idle.
    task automatic op(input bit sel, input bit wr, input logic [2:0] a,
                      input logic [31:0] d, input bit rdy, input bit opd);
        drive(sel, wr, a, d, rdy, opd);
        drive(0, 0, 3'd0, 32'd0, 0, 0);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        op(1, 1, a, d, 0, 0);
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        op(1, 0, a, 32'd0, 0, 0);
        check(name, s_dout, exp);
    endtask

    task automatic pop_chk(input logic [31:0] exp_src, input string name);
        check({name, "_valid"}, desc_valid, 1'b1);
        check({name, "_src"}, desc_src, exp_src);
        op(0, 0, 3'd0, 32'd0, 1, 0);
    endtask

    task automatic opdone();
        op(0, 0, 3'd0, 32'd0, 0, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) bus_rd(3'(i), 32'd0, "rst_read");
        check("rst_irq", irq, 1'b0);
        check("rst_desc_valid", desc_valid, 1'b0);
        check("rst_desc_src", desc_src, 32'd0);
        check("rst_desc_size", desc_size, 16'd0);

        // Single descriptor
        bus_wr(3'd3, 32'h1000);
        bus_wr(3'd4, 32'h2000);
        bus_wr(3'd5, 32'hFFFF_0040);
        bus_rd(3'd5, 32'h0040, "size_upper_zero");
        bus_wr(3'd0, 32'd1);
        check("one_valid", desc_valid, 1'b1);
        check("one_src", desc_src, 32'h1000);
        check("one_dst", desc_dst, 32'h2000);
        check("one_size", desc_size, 16'h0040);
        bus_rd(3'd6, 32'h101, "status_one");
        pop_chk(32'h1000, "one_pop");
        opdone();
        bus_rd(3'd1, 32'd1, "intr_no_en");
        check("irq_masked", irq, 1'b0);
        bus_wr(3'd1, 32'd1);
        bus_rd(3'd1, 32'd0, "intr_w1c");

        // Overflow: five pushes into a depth-4 queue
        for (int k = 1; k <= 5; k++) begin
            bus_wr(3'd3, 32'(k));
            bus_wr(3'd0, 32'd1);
        end
        bus_rd(3'd6, 32'h403, "status_full_ovf");
        for (int k = 1; k <= 4; k++) pop_chk(32'(k), "ovf_pop");
        check("ovf_drained", desc_valid, 1'b0);
        bus_wr(3'd6, 32'h2);
        bus_rd(3'd6, 32'h1, "ovf_cleared_busy");
        repeat (4) opdone();
        bus_rd(3'd6, 32'h0, "status_idle");
        bus_wr(3'd1, 32'd1);

        // Interrupt with enable
        bus_wr(3'd2, 32'd1);
        bus_wr(3'd3, 32'hAA);
        bus_wr(3'd0, 32'd1);
        pop_chk(32'hAA, "irq_pop");
        check("irq_before_done", irq, 1'b0);
        opdone();
        check("irq_after_done", irq, 1'b1);
        bus_rd(3'd1, 32'd1, "intr_set");
        bus_rd(3'd6, 32'd0, "status_not_busy");
        bus_wr(3'd1, 32'd1);
        check("irq_cleared", irq, 1'b0);

        // Push into a full queue while popping
        for (int k = 'h11; k <= 'h14; k++) begin
            bus_wr(3'd3, 32'(k));
            bus_wr(3'd0, 32'd1);
        end
        bus_wr(3'd3, 32'h15);
        op(1, 1, 3'd0, 32'd1, 1, 0);
        bus_rd(3'd6, 32'h401, "status_full_no_ovf");
        for (int k = 'h12; k <= 'h15; k++) pop_chk(32'(k), "full_pop");
        check("full_drained", desc_valid, 1'b0);
        repeat (5) opdone();
        bus_wr(3'd1, 32'd1);

        // Reset with two queued and one in flight
        bus_wr(3'd3, 32'h31);
        repeat (3) bus_wr(3'd0, 32'd1);
        pop_chk(32'h31, "pre_rst_pop");
        bus_wr(3'd1, 32'd0);
        reset = 1'b1;
        #1;
        check("arst_desc_valid", desc_valid, 1'b0);
        check("arst_irq", irq, 1'b0);
        check("arst_desc_src", desc_src, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_rd(3'd6, 32'd0, "post_rst_status");
        bus_rd(3'd2, 32'd0, "post_rst_int_en");
        opdone();
        bus_rd(3'd1, 32'd0, "post_rst_intr");
        bus_rd(3'd6, 32'd0, "post_rst_status2");

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 499) == 0);
            s_sel      = ($urandom_range(0, 99) < 60);
            s_wr       = 1'($urandom_range(0, 1));
            s_addr     = 3'($urandom_range(0, 7));
            s_din      = $urandom;
            if ($urandom_range(0, 1) == 1) s_din[0] = 1'b1;
            desc_ready = ($urandom_range(0, 3) == 0);
            op_done    = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        s_sel = 1'b0; s_wr = 1'b0; desc_ready = 1'b0; op_done = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
